// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract; each stage resolves one SLICE-bit slice and registers the carry for the next.
// Latency STAGES cycles from accept to out_valid, 1 op/cycle sustained; results leave in issue order.
// Backpressure: full stages hold while the stage ahead is blocked, empty stages still fill; in_ready is combinational from out_ready.

module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : gBadParams
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    // Operand registers travel whole; bits below the current slice are dead and
    // get trimmed by synthesis. The MSBs double as the stored sign bits.
    logic             vld    [STAGES];
    logic             adv    [STAGES];
    logic             carry  [STAGES];
    logic [WIDTH-1:0] opA    [STAGES];
    logic [WIDTH-1:0] opB    [STAGES];
    logic [WIDTH-1:0] sumAcc [STAGES];

    // A stage may load unless it and every stage ahead of it are full and the
    // output is blocked; written flat to avoid a ripple through adv itself.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!vld[j]) begin
                    adv[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        logic [WIDTH-1:0] srcA;
        logic [WIDTH-1:0] srcB;
        logic [WIDTH-1:0] srcSum;
        logic             srcCarry;
        logic             srcVld;
        logic [SLICE:0]   part;
        logic [WIDTH-1:0] nxtSum;

        if (k == 0) begin : gHead
            assign srcA     = inputA;
            assign srcB     = sub ? ~inputB : inputB;
            assign srcSum   = '0;
            assign srcCarry = sub | cin;
            assign srcVld   = in_valid;
        end else begin : gBody
            assign srcA     = opA[k-1];
            assign srcB     = opB[k-1];
            assign srcSum   = sumAcc[k-1];
            assign srcCarry = carry[k-1];
            assign srcVld   = vld[k-1];
        end

        assign part = {1'b0, srcA[k*SLICE +: SLICE]}
                    + {1'b0, srcB[k*SLICE +: SLICE]}
                    + {{SLICE{1'b0}}, srcCarry};

        always_comb begin
            nxtSum = srcSum;
            nxtSum[k*SLICE +: SLICE] = part[SLICE-1:0];
        end

        // Bubbles only clear the valid bit, so a drained output keeps its last value.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld[k]    <= 1'b0;
                carry[k]  <= 1'b0;
                opA[k]    <= '0;
                opB[k]    <= '0;
                sumAcc[k] <= '0;
            end else if (adv[k]) begin
                vld[k] <= srcVld;
                if (srcVld) begin
                    carry[k]  <= part[SLICE];
                    opA[k]    <= srcA;
                    opB[k]    <= srcB;
                    sumAcc[k] <= nxtSum;
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[LAST];
    assign Sum       = sumAcc[LAST];
    assign Carry     = carry[LAST];
    assign Overflow  = (opA[LAST][WIDTH-1] == opB[LAST][WIDTH-1])
                    && (sumAcc[LAST][WIDTH-1] != opA[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed and random traffic on a 32/4 instance plus {8,1},{16,2},{64,8} sweeps.
// Expected results come from plain wide-integer arithmetic and are matched in order by per-instance monitors.
module tb_pipelined_adder;
    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        int          t;
        bit          lat;
    } exp_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: unsigned and signed results from ordinary integer maths.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic s, input logic ci, input int w);
        exp_t e;
        logic [127:0] ua, ub, ur;
        logic signed [127:0] sa, sb, sr, lim;
        logic [63:0] mask;
        ua = {64'b0, a};
        ub = {64'b0, b};
        sa = $signed(ua);
        sb = $signed(ub);
        if (a[w-1]) sa = sa - (128'sd1 <<< w);
        if (b[w-1]) sb = sb - (128'sd1 <<< w);
        if (s) begin
            ur  = ua - ub;
            e.c = (ua >= ub);
            sr  = sa - sb;
        end else begin
            ur  = ua + ub + {127'b0, ci};
            e.c = ur[w];
            sr  = sa + sb + $signed({127'b0, ci});
        end
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        e.s  = ur[63:0] & mask;
        lim  = 128'sd1 <<< (w - 1);
        e.o  = (sr >= lim) || (sr < -lim);
        e.t  = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, got, want);
        end
    endtask

    // ---------------- main 32/4 instance ----------------
    logic        rst, in_valid, in_ready, sub, cin, out_valid, out_ready, Carry, Overflow;
    logic [31:0] inputA, inputB, Sum;
    bit          swRst = 1'b1;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inputA(inputA), .inputB(inputB), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Carry(Carry), .Overflow(Overflow)
    );

    exp_t q[$];
    int   stalls = 0;
    int   runLen = 0;
    int   maxRun = 0;
    bit   randReady = 1'b0;
    bit   drvDone = 1'b0;

    always @(negedge clk) begin
        exp_t h;
        if (rst) begin
            runLen = 0;
        end else if (out_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out got sum=%h with nothing outstanding", Sum);
            end else begin
                h = q[0];
                if ({Sum, Carry, Overflow} !== {h.s[31:0], h.c, h.o}) begin
                    bad++;
                    $display("FAIL %s got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                             out_ready ? "result" : "held_result", Sum, Carry, Overflow,
                             h.s[31:0], h.c, h.o);
                end
                if (out_ready) begin
                    if (h.lat) begin
                        total++;
                        if (cyc - h.t != 4) begin
                            bad++;
                            $display("FAIL latency got=%0d want=4", cyc - h.t);
                        end
                    end
                    void'(q.pop_front());
                    runLen++;
                    if (runLen > maxRun) maxRun = runLen;
                end else begin
                    runLen = 0;
                end
            end
        end else begin
            runLen = 0;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic ci, input bit lat);
        exp_t e;
        int   w = 0;
        in_valid = 1'b1; inputA = a; inputB = b; sub = s; cin = ci;
        @(negedge clk);
        if (!in_ready) stalls++;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL issue_timeout got in_ready=0 want 1 within 200 cycles");
        end else begin
            e = model(64'(a), 64'(b), s, ci, 32);
            e.t = cyc;
            e.lat = lat;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_outstanding", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b1; inputA = 32'd3; inputB = 32'd4; sub = 1'b0; cin = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({in_ready, out_valid, Sum, Carry, Overflow}), 64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));
        rst = 1'b0; swRst = 1'b0; in_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end

        // carry-in and latency
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        drain();

        // subtract, borrow, signed overflow
        issue(32'd5, 32'd7, 1'b0 | 1'b1, 1'b0, 1'b1);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        issue(32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        issue(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        drain();

        // back-to-back throughput
        stalls = 0; maxRun = 0;
        for (int i = 0; i < 16; i++) issue($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        drain();
        chk("tput_in_ready_drops", 64'(stalls), 64'd0);
        chk("tput_consecutive_out", 64'(maxRun), 64'd16);

        // backpressure: pipe fills, holds, then drains in order
        out_ready = 1'b0; drvDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                drvDone = 1'b1;
            end
        join_none
        repeat (10) @(negedge clk);
        chk("bp_accepted", 64'(q.size()), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        w = 0;
        while (!drvDone && w < 300) begin @(negedge clk); w++; end
        chk("bp_driver_done", 64'(drvDone), 64'd1);
        drain();

        // reset with three ops in flight
        for (int i = 0; i < 3; i++) issue($urandom(), $urandom(), 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_state", 64'({out_valid, Sum, in_ready}), 64'({1'b0, 32'h0, 1'b1}));
        repeat (10) begin @(posedge clk); #1; end

        // random traffic with random backpressure
        randReady = 1'b1;
        fork
            while (randReady) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        randReady = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        w = 0;
        while (!(gSweep[0].done && gSweep[1].done && gSweep[2].done) && w < 90000) begin
            @(negedge clk);
            w++;
        end
        chk("sweeps_done", 64'({gSweep[0].done, gSweep[1].done, gSweep[2].done}), 64'b111);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- parameter sweep ----------------
    for (genvar g = 0; g < 3; g++) begin : gSweep
        localparam int SW   = (g == 0) ? 8 : (g == 1) ? 16 : 64;
        localparam int SS   = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        localparam int NOPS = (g == 0) ? 65536 : 400;

        logic          iv, ir, s, ci, ov, ordy, c, o;
        logic [SW-1:0] a, b, sm;
        exp_t          sq[$];
        bit            done = 1'b0;

        pipelined_adder #(.WIDTH(SW), .STAGES(SS)) dut (
            .clk(clk), .rst(swRst), .in_valid(iv), .in_ready(ir),
            .inputA(a), .inputB(b), .sub(s), .cin(ci),
            .out_valid(ov), .out_ready(ordy),
            .Sum(sm), .Carry(c), .Overflow(o)
        );

        always @(negedge clk) begin
            exp_t h;
            if (!swRst && ov) begin
                total++;
                if (sq.size() == 0) begin
                    bad++;
                    $display("FAIL sweep%0d_unexpected_out got sum=%h", SW, sm);
                end else begin
                    h = sq[0];
                    if ({sm, c, o} !== {h.s[SW-1:0], h.c, h.o}) begin
                        bad++;
                        $display("FAIL sweep%0d_result got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                                 SW, sm, c, o, h.s[SW-1:0], h.c, h.o);
                    end
                    if (ordy) begin
                        if (h.lat) begin
                            total++;
                            if (cyc - h.t != SS) begin
                                bad++;
                                $display("FAIL sweep%0d_latency got=%0d want=%0d", SW, cyc - h.t, SS);
                            end
                        end
                        void'(sq.pop_front());
                    end
                end
            end
        end

        initial begin
            exp_t        e;
            int          w;
            logic [63:0] ra, rb, idx, idxB;
            iv = 1'b0; a = '0; b = '0; s = 1'b0; ci = 1'b0; ordy = 1'b1;
            wait (!swRst);
            @(posedge clk); #1;
            for (int i = -1; i < NOPS; i++) begin
                ra   = {$urandom(), $urandom()};
                rb   = {$urandom(), $urandom()};
                idx  = 64'(i);
                idxB = 64'(i) >> 8;
                iv = 1'b1;
                a  = (NOPS > 1000 && i >= 0) ? idx[SW-1:0]  : ra[SW-1:0];
                b  = (NOPS > 1000 && i >= 0) ? idxB[SW-1:0] : rb[SW-1:0];
                s  = 1'($urandom_range(0, 1));
                ci = 1'($urandom_range(0, 1));
                if (i > 0 && NOPS < 1000) ordy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                w = 0;
                while (!ir && w < 200) begin
                    @(posedge clk); #1;
                    ordy = ($urandom_range(0, 1) == 1);
                    @(negedge clk);
                    w++;
                end
                if (!ir) begin
                    total++; bad++;
                    $display("FAIL sweep%0d_issue_timeout got in_ready=0 want 1", SW);
                end else begin
                    e = model(64'(a), 64'(b), s, ci, SW);
                    e.t = cyc;
                    e.lat = (i < 0);
                    sq.push_back(e);
                end
                @(posedge clk); #1;
                if (i < 0) begin
                    iv = 1'b0;
                    w = 0;
                    while (sq.size() != 0 && w < 50) begin @(posedge clk); #1; w++; end
                end
            end
            iv = 1'b0;
            ordy = 1'b1;
            w = 0;
            while (sq.size() != 0 && w < 500) begin @(negedge clk); w++; end
            chk($sformatf("sweep%0d_drain", SW), 64'(sq.size()), 64'd0);
            done = 1'b1;
        end
    end
endmodule
